// File: rtl/fibonacci_checker_if.sv
// Beat stream into the Fibonacci checker: one or two W-bit terms per
// valid/ready transfer, with in_data always the earlier term.
interface fibonacci_checker_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         in_two;
  logic [W-1:0] in_data;
  logic [W-1:0] in_data2;

  modport master (
    output in_valid,
    output in_two,
    output in_data,
    output in_data2,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_two,
    input  in_data,
    input  in_data2,
    output in_ready
  );
endinterface

// File: rtl/fibonacci_checker.sv
// Receive-side Fibonacci stream checker: verifies single- or double-rate beats
// against the recurrence mod 2^W, latches the first mismatch, counts matches.
module fibonacci_checker #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  fibonacci_checker_if.slave   in_if,
  output logic                 error,
  output logic                 err_lane,
  output logic [W-1:0]         err_expected,
  output logic [W-1:0]         err_got,
  output logic [CNT_W-1:0]     match_count
);

  typedef enum logic [1:0] {
    ST_CHECK = 2'd0,
    ST_SEED0 = 2'd1,
    ST_SEED1 = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0]     ONE_W   = {{(W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [W-1:0]       exp0_q, exp0_d;
  logic [W-1:0]       exp1_q, exp1_d;
  logic [W-1:0]       seed_a_q, seed_a_d;
  logic               error_q, error_d;
  logic               err_lane_q, err_lane_d;
  logic [W-1:0]       err_expected_q, err_expected_d;
  logic [W-1:0]       err_got_q, err_got_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         cnt_inc;

  logic               ready;
  logic               accept;
  logic [W-1:0]       chk_s0, chk_s1;
  logic [W-1:0]       seed0_s0, seed0_s1;
  logic [W-1:0]       seed1_s0, seed1_s1, seed1_s2;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    if (s > {1'b0, CNT_MAX}) begin
      return CNT_MAX;
    end
    return s[CNT_W-1:0];
  endfunction

  // A beat offered alongside rst or restart is never consumed.
  assign ready          = (state_q != ST_ERROR) & ~restart & ~rst;
  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid & ready;

  // Next two terms after a fully matched two-lane beat.
  assign chk_s0   = exp0_q + exp1_q;
  assign chk_s1   = chk_s0 + exp1_q;

  // Seeds a,b give expected terms a+b and a+2b; sums wrap to W bits.
  assign seed0_s0 = in_if.in_data + in_if.in_data2;
  assign seed0_s1 = seed0_s0 + in_if.in_data2;
  assign seed1_s0 = seed_a_q + in_if.in_data;
  assign seed1_s1 = seed1_s0 + in_if.in_data;
  assign seed1_s2 = seed1_s0 + seed1_s1;

  always_comb begin
    state_d        = state_q;
    exp0_d         = exp0_q;
    exp1_d         = exp1_q;
    seed_a_d       = seed_a_q;
    error_d        = error_q;
    err_lane_d     = err_lane_q;
    err_expected_d = err_expected_q;
    err_got_d      = err_got_q;
    cnt_inc        = 2'd0;
    count_d        = count_q;

    if (restart) begin
      state_d        = ST_SEED0;
      error_d        = 1'b0;
      err_lane_d     = 1'b0;
      err_expected_d = '0;
      err_got_d      = '0;
      count_d        = '0;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (accept) begin
            if (in_if.in_data != exp0_q) begin
              state_d        = ST_ERROR;
              error_d        = 1'b1;
              err_lane_d     = 1'b0;
              err_expected_d = exp0_q;
              err_got_d      = in_if.in_data;
            end else if (!in_if.in_two) begin
              exp0_d  = exp1_q;
              exp1_d  = chk_s0;
              cnt_inc = 2'd1;
            end else if (in_if.in_data2 != exp1_q) begin
              state_d        = ST_ERROR;
              error_d        = 1'b1;
              err_lane_d     = 1'b1;
              err_expected_d = exp1_q;
              err_got_d      = in_if.in_data2;
              cnt_inc        = 2'd1;
            end else begin
              exp0_d  = chk_s0;
              exp1_d  = chk_s1;
              cnt_inc = 2'd2;
            end
          end
        end

        ST_SEED0: begin
          if (accept) begin
            if (!in_if.in_two) begin
              seed_a_d = in_if.in_data;
              state_d  = ST_SEED1;
            end else begin
              exp0_d  = seed0_s0;
              exp1_d  = seed0_s1;
              state_d = ST_CHECK;
            end
          end
        end

        ST_SEED1: begin
          if (accept) begin
            if (!in_if.in_two) begin
              exp0_d  = seed1_s0;
              exp1_d  = seed1_s1;
              state_d = ST_CHECK;
            end else if (in_if.in_data2 != seed1_s0) begin
              // in_data closed the seed; only in_data2 is a checked term.
              exp0_d         = seed1_s0;
              exp1_d         = seed1_s1;
              state_d        = ST_ERROR;
              error_d        = 1'b1;
              err_lane_d     = 1'b1;
              err_expected_d = seed1_s0;
              err_got_d      = in_if.in_data2;
            end else begin
              exp0_d  = seed1_s1;
              exp1_d  = seed1_s2;
              state_d = ST_CHECK;
              cnt_inc = 2'd1;
            end
          end
        end

        default: begin
          state_d = ST_ERROR;
        end
      endcase
      count_d = sat_add(count_q, cnt_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_CHECK;
      exp0_q         <= ONE_W;
      exp1_q         <= ONE_W;
      seed_a_q       <= '0;
      error_q        <= 1'b0;
      err_lane_q     <= 1'b0;
      err_expected_q <= '0;
      err_got_q      <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      exp0_q         <= exp0_d;
      exp1_q         <= exp1_d;
      seed_a_q       <= seed_a_d;
      error_q        <= error_d;
      err_lane_q     <= err_lane_d;
      err_expected_q <= err_expected_d;
      err_got_q      <= err_got_d;
      count_q        <= count_d;
    end
  end

  assign error        = error_q;
  assign err_lane     = err_lane_q;
  assign err_expected = err_expected_q;
  assign err_got      = err_got_q;
  assign match_count  = count_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: the driver pushes the expected status
// per consumed beat/restart/reset, and a monitor pops and compares independently.
module tb_fibonacci_checker;
  localparam int W       = 16;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               restart = 1'b0;
  logic               error, err_lane;
  logic [W-1:0]       err_expected, err_got;
  logic [CNT_W-1:0]   match_count;

  fibonacci_checker_if #(.W(W)) bus ();

  fibonacci_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .in_if        (bus),
    .error        (error),
    .err_lane     (err_lane),
    .err_expected (err_expected),
    .err_got      (err_got),
    .match_count  (match_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             err;
    logic             lane;
    logic [W-1:0]     exp;
    logic [W-1:0]     got;
    logic [CNT_W-1:0] cnt;
  } snap_t;

  snap_t sb_q[$];
  int    checks  = 0;
  int    passes  = 0;
  bit    verbose = 1'b1;

  // Reference model: the stream is a sequence of words where, once the free
  // seed words are used up, every word must equal the sum of the previous two.
  logic [W-1:0] m_h0, m_h1;
  int           m_free;
  bit           m_err;
  logic         m_lane;
  logic [W-1:0] m_exp, m_got;
  int           m_cnt;

  function automatic void model_clear(input int free_words);
    m_err  = 1'b0;
    m_lane = 1'b0;
    m_exp  = '0;
    m_got  = '0;
    m_cnt  = 0;
    m_free = free_words;
    m_h0   = 16'd1;   // so that the first two expected words after reset are 1, 1
    m_h1   = 16'd0;
  endfunction

  function automatic void model_word(input logic lane, input logic [W-1:0] w);
    logic [W-1:0] e;
    if (m_err) return;
    if (m_free > 0) begin
      m_h0 = m_h1;
      m_h1 = w;
      m_free--;
      return;
    end
    e = m_h0 + m_h1;
    if (w == e) begin
      m_h0 = m_h1;
      m_h1 = w;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_err  = 1'b1;
      m_lane = lane;
      m_exp  = e;
      m_got  = w;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.err  = m_err;
    s.lane = m_lane;
    s.exp  = m_exp;
    s.got  = m_got;
    s.cnt  = m_cnt[CNT_W-1:0];
    return s;
  endfunction

  task automatic check(input string name, input longint got, input longint req);
    checks++;
    if (got == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, got, req);
  endtask

  // One clock of stimulus: drive at the falling edge, sample ready just after.
  task automatic drive(input bit v, input bit two, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input bit rt, input bit rs);
    bit exp_ready;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_two   = two;
    bus.in_data  = d0;
    bus.in_data2 = d1;
    restart      = rt;
    rst          = rs;
    #1;
    exp_ready = !m_err && !rt && !rs;
    check("in_ready", longint'(bus.in_ready), longint'(exp_ready));
    if (rs) begin
      model_clear(0);
      sb_q.push_back(model_snap());
    end else if (rt) begin
      model_clear(2);
      sb_q.push_back(model_snap());
    end else if (v && exp_ready) begin
      model_word(1'b0, d0);
      if (two) model_word(1'b1, d1);
      sb_q.push_back(model_snap());
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic one(input logic [W-1:0] d);
    drive(1'b1, 1'b0, d, '0, 1'b0, 1'b0);
  endtask

  task automatic two(input logic [W-1:0] d0, input logic [W-1:0] d1);
    drive(1'b1, 1'b1, d0, d1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_restart();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: each consumed beat, restart or reset yields one status to compare.
  initial begin : monitor
    bit    ev;
    snap_t act, req;
    ev = 1'b0;
    forever begin
      @(negedge clk);
      if (ev) begin
        act = {error, err_lane, err_expected, err_got, match_count};
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL txn: DUT consumed a beat with no expected status queued (cnt=%0d err=%0d)",
                   match_count, error);
        end else begin
          req = sb_q.pop_front();
          if (act == req) passes++;
          else $display("FAIL txn: got err=%0d lane=%0d exp=%0d got=%0d cnt=%0d, required err=%0d lane=%0d exp=%0d got=%0d cnt=%0d",
                        act.err, act.lane, act.exp, act.got, act.cnt,
                        req.err, req.lane, req.exp, req.got, req.cnt);
          if (verbose)
            $display("txn t=%0t err=%0d lane=%0d exp=%0d got=%0d cnt=%0d",
                     $time, act.err, act.lane, act.exp, act.got, act.cnt);
        end
      end
      #2;
      ev = rst | restart | (bus.in_valid & bus.in_ready);
    end
  end

  initial begin : stimulus
    logic [W-1:0] seq1[6];
    logic [W-1:0] a, b, c, d, w0, w1, th0, th1;
    int           tfree, r;
    seq1 = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    bus.in_valid = 1'b0;
    bus.in_two   = 1'b0;
    bus.in_data  = '0;
    bus.in_data2 = '0;
    model_clear(0);

    // Single-lane run
    do_reset();
    foreach (seq1[i]) one(seq1[i]);
    idle();
    check("t1_count", match_count, 6);
    check("t1_error", error, 0);

    // Two-lane run
    do_reset();
    two(16'd1, 16'd1);
    two(16'd2, 16'd3);
    two(16'd5, 16'd8);
    two(16'd13, 16'd21);
    idle();
    check("t2_count", match_count, 8);

    // Wrap-around through F26, then a wrong word
    do_reset();
    a = 16'd1;
    b = 16'd1;
    for (int i = 0; i < 26; i++) begin
      one(a);
      c = a + b;
      a = b;
      b = c;
    end
    idle();
    check("t3_count", match_count, 26);
    one(16'd0);
    idle();
    check("t3_error", error, 1);
    check("t3_err_expected", err_expected, 65346);
    check("t3_err_got", err_got, 0);

    // Lane-1 mismatch
    do_reset();
    two(16'd1, 16'd1);
    two(16'd2, 16'd4);
    idle();
    check("t4_error", error, 1);
    check("t4_err_lane", err_lane, 1);
    check("t4_err_expected", err_expected, 3);
    check("t4_err_got", err_got, 4);
    check("t4_count", match_count, 3);
    check("t4_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) one(16'd3);
    check("t4_count_held", match_count, 3);

    // Re-seeding from ERROR
    do_restart();
    one(16'd10);
    one(16'd20);
    one(16'd30);
    one(16'd50);
    one(16'd80);
    idle();
    check("t5_error", error, 0);
    check("t5_count", match_count, 3);
    do_restart();
    two(16'd3, 16'd4);
    one(16'd7);
    idle();
    check("t5_two_seed_count", match_count, 1);

    // Beat offered with restart is dropped; rst beats restart/ERROR
    drive(1'b1, 1'b0, 16'd99, '0, 1'b1, 1'b0);
    one(16'd5);
    one(16'd6);
    one(16'd11);
    idle();
    check("t6_drop_count", match_count, 1);
    check("t6_drop_error", error, 0);
    one(16'd0);
    idle();
    check("t6_err_set", error, 1);
    drive(1'b1, 1'b0, 16'd1, '0, 1'b1, 1'b1);
    idle();
    check("t6_rst_error", error, 0);
    check("t6_rst_count", match_count, 0);
    one(16'd1);
    idle();
    check("t6_first_word", match_count, 1);

    // Saturation: two-lane beats up to max-1, then +2 clamps at max
    do_reset();
    verbose = 1'b0;
    a = 16'd1;
    b = 16'd1;
    for (int i = 0; i < (CNT_MAX - 1) / 2; i++) begin
      two(a, b);
      c = a + b;
      d = b + c;
      a = c;
      b = d;
    end
    idle();
    check("t7_max_minus1", match_count, CNT_MAX - 1);
    two(a, b);
    c = a + b;
    d = b + c;
    idle();
    check("t7_sat_two", match_count, CNT_MAX);
    one(c);
    idle();
    check("t7_sat_hold", match_count, CNT_MAX);
    check("t7_error", error, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      verbose = (i < 40);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive($urandom_range(0, 1) == 1, 1'b0, 16'($urandom), '0, 1'b0, 1'b1);
      end else if (r < 4 || (m_err && r < 30)) begin
        drive($urandom_range(0, 1) == 1, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      end else if (r < 15) begin
        idle();
      end else begin
        th0   = m_h0;
        th1   = m_h1;
        tfree = m_free;
        w0 = (tfree > 0 || $urandom_range(0, 19) == 0) ? 16'($urandom) : th0 + th1;
        if (tfree > 0) tfree--;
        th0 = th1;
        th1 = w0;
        w1 = (tfree > 0 || $urandom_range(0, 19) == 0) ? 16'($urandom) : th0 + th1;
        drive(1'b1, $urandom_range(0, 1) == 1, w0, w1, 1'b0, 1'b0);
      end
    end
    verbose = 1'b1;
    idle();
    idle();
    idle();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
- Receive-side counterpart of the team's single- and double-rate Fibonacci generators.
- Consumes a stream of one or two W-bit words per beat on a valid/ready handshake.
- Checks the stream against the Fibonacci recurrence, modulo 2^W.
- Reports the first mismatch with diagnostic capture and counts matched words; supports re-seeding on an arbitrary pair.

Parameters:
W, 16, data word width; all arithmetic is mod 2^W.
CNT_W, 16, width of match_count.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
restart  input  1  single-cycle request to clear error/count and enter seeding
in_valid  input  1  beat offered
in_ready  output  1  checker can accept a beat
in_two  input  1  1: in_data and in_data2 both carry terms (in_data earlier); 0: in_data only
in_data  input  W  first (or only) term of beat
in_data2  input  W  second term; ignored when in_two=0
error  output  1  sticky mismatch flag
err_lane  output  1  lane of first mismatch (0=in_data, 1=in_data2)
err_expected  output  W  expected value at mismatch
err_got  output  W  received value at mismatch
match_count  output  CNT_W  count of words matched in CHECK, saturating

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high, ports clk and rst.
- Accept = in_valid & in_ready. in_ready = (state != ERROR) & ~restart, combinational. A beat offered while in_ready=0 is not consumed; the source holds it.
- Internal state: exp0, exp1 (next two expected terms).
- Reset values:
  - state=CHECK, exp0=1, exp1=1.
  - error=0, err_lane=0, err_expected=0, err_got=0, match_count=0.
- All outputs other than in_ready are registered; error and err_* are valid the cycle after the offending beat.
- States:
  - CHECK, single-lane accept:
    - in_data==exp0 -> {exp0,exp1} <= {exp1, exp0+exp1}; count +1.
    - else -> ERROR.
  - CHECK, two-lane accept:
    - Compare in_data vs exp0, then in_data2 vs exp1.
    - Both match -> {exp0,exp1} <= {exp0+exp1, exp0+2*exp1} (all mod 2^W); count +2.
    - Lane0 mismatch -> ERROR, err_lane=0, lane1 not evaluated, count unchanged.
    - Lane0 match, lane1 mismatch -> count +1, ERROR, err_lane=1.
  - ERROR, entry:
    - error=1; capture err_expected and err_got for the failing lane.
    - Held until restart or rst; exp0/exp1 frozen; in_ready=0.
  - SEED0:
    - Single-lane accept captures a=in_data -> SEED1.
    - Two-lane accept captures a=in_data, b=in_data2 -> exp0=a+b, exp1=a+2b -> CHECK.
  - SEED1:
    - Single-lane accept captures b=in_data -> exp0=a+b, exp1=a+2b -> CHECK.
    - Two-lane accept: in_data is b (seed completes); in_data2 is then checked against a+b in the same beat under CHECK rules.
    - Seed words are never counted and never cause error.
- restart, in any state:
  - Next state SEED0; error, err_lane, err_expected, err_got and match_count cleared to 0.
  - Any beat offered that cycle is dropped (in_ready=0).
- rst has priority over restart, mid-operation included; it returns to CHECK with exp {1,1}.
- match_count saturates at 2^CNT_W-1. A two-lane +2 from max-1 yields max.
- Wrap-around: sums truncate to W bits with no overflow flag, so the checker matches a generator that wraps identically.
- Simultaneous in_valid and rst: the beat is not consumed and has no effect.

Test Plan:
1. Reset, single-lane 1,1,2,3,5,8 -> error=0, match_count=6, in_ready=1 throughout.
2. Reset, two-lane beats (1,1),(2,3),(5,8),(13,21) -> error=0, match_count=8.
3. Reset, single-lane F1..F26 with truncation: F25 sent as 9489, F26 as 55857 -> error=0, match_count=26. Then send 0 -> error=1, err_expected=65346 (9489+55857 mod 65536), err_got=0.
4. Reset, two-lane (1,1), then (2,4) -> next cycle:
   - error=1, err_lane=1, err_expected=3, err_got=4, match_count=3, in_ready=0.
   - Further in_valid is not consumed.
5. From ERROR:
   - restart, single seeds 10 then 20, then 30,50,80 -> error=0, match_count=3.
   - restart, two-lane seed (3,4), then single 7 -> match_count=1.
6. Priority and drop checks:
   - restart asserted with in_valid=1, in_data=99 -> beat dropped and not used as a seed.
   - rst pulsed while in ERROR -> error=0, match_count=0, next accepted word 1 matches.
